// File: rtl/pipe_debug_ctrl.sv
// rtl/pipe_debug_ctrl.sv - UART-driven debug controller for the pipelined processor
//
// Decodes single-byte host commands and drives the pipeline's gated clock and
// reset. It runs the pipeline in step or free-run mode. After a halt it streams
// a DATA_BYTES-long snapshot back through the UART transmitter, LSB byte first.
// Optional PC breakpoint support is compiled in when DEBUG_BREAKPOINT_EN is defined.
//
// Ports:
//   top_clk, top_rst   : clock, synchronous active-high reset
//   rx_done_tick/rx_bus: received host byte strobe and data
//   tx_done_tick       : transmitter finished the current byte
//   instruccion        : fetched instruction (zero-streak halt detection)
//   pc                 : fetch PC (breakpoint compare; unused without the feature)
//   send_data          : snapshot bus, 8*DATA_BYTES bits
//   clk_pipe, rst_pipe : pipeline clock and reset
//   tx_start, tx_bus   : transmit strobe and byte (buffer[7:0])
//   busy               : controller is not in IDLE
module pipe_debug_ctrl #(
  parameter int DATA_BYTES    = 172,
  parameter int INSTR_W       = 32,
  parameter int PC_W          = 32,
  parameter int HALT_ZERO_CNT = 5,
  parameter int RST_CYCLES    = 1
) (
  input  logic                    top_clk,
  input  logic                    top_rst,
  input  logic                    rx_done_tick,
  input  logic [7:0]              rx_bus,
  input  logic                    tx_done_tick,
  input  logic [INSTR_W-1:0]      instruccion,
  input  logic [PC_W-1:0]         pc,
  input  logic [8*DATA_BYTES-1:0] send_data,
  output logic                    clk_pipe,
  output logic                    rst_pipe,
  output logic                    tx_start,
  output logic [7:0]              tx_bus,
  output logic                    busy
);

  localparam int REM_W = $clog2(DATA_BYTES + 1);
  localparam int ZC_W  = $clog2(HALT_ZERO_CNT + 1);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_STEP_HI    = 4'd1;
  localparam logic [3:0] S_STEP_LO    = 4'd2;
  localparam logic [3:0] S_RUN_CHK    = 4'd3;
  localparam logic [3:0] S_RUN_HI     = 4'd4;
  localparam logic [3:0] S_RUN_LO     = 4'd5;
  localparam logic [3:0] S_RESET      = 4'd6;
  localparam logic [3:0] S_BP_LOAD    = 4'd7;
  localparam logic [3:0] S_CAPTURE    = 4'd8;
  localparam logic [3:0] S_SEND_START = 4'd9;
  localparam logic [3:0] S_SEND_WAIT  = 4'd10;

  localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
  localparam logic [7:0] CMD_CONT  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_RST   = 8'h72;  // 'r'
  localparam logic [7:0] CMD_DUMP  = 8'h64;  // 'd'
  localparam logic [7:0] CMD_HALT  = 8'h68;  // 'h'
`ifdef DEBUG_BREAKPOINT_EN
  localparam logic [7:0] CMD_BP    = 8'h62;  // 'b'
  localparam logic [7:0] CMD_CLRBP = 8'h78;  // 'x'
  localparam int BP_BYTES = PC_W / 8;
  localparam int BPC_W    = $clog2(BP_BYTES + 1);
`endif

  logic [3:0]              state;
  logic [8*DATA_BYTES-1:0] buffer;
  logic [REM_W-1:0]        remaining;
  logic [ZC_W-1:0]         zero_cnt;
  logic [ZC_W-1:0]         nz;
  logic [RC_W-1:0]         rst_cnt;
  logic                    host_halt;
  logic                    bp_hit;

`ifdef DEBUG_BREAKPOINT_EN
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  rx_ext;
  logic             bp_valid;
  logic             first_chk;  // suppresses a hit on the first check so a run can leave a breakpoint
  logic [BPC_W-1:0] bp_cnt;

  assign rx_ext = PC_W'(rx_bus);
  assign bp_hit = bp_valid && !first_chk && (pc == bp_addr);
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign bp_hit    = 1'b0;
`endif

  assign host_halt = rx_done_tick && (rx_bus == CMD_HALT);
  assign tx_bus    = buffer[7:0];
  assign busy      = (state != S_IDLE);

  // Next zero-streak length, evaluated against the instruction fetched now.
  always_comb begin
    nz = '0;
    if (instruccion == '0) nz = zero_cnt + ZC_W'(1);
  end

  always_ff @(posedge top_clk) begin
    if (top_rst) begin
      state     <= S_IDLE;
      clk_pipe  <= 1'b0;
      rst_pipe  <= 1'b0;
      tx_start  <= 1'b0;
      buffer    <= '0;
      remaining <= '0;
      zero_cnt  <= '0;
      rst_cnt   <= '0;
`ifdef DEBUG_BREAKPOINT_EN
      bp_addr   <= '0;
      bp_valid  <= 1'b0;
      first_chk <= 1'b0;
      bp_cnt    <= '0;
`endif
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_done_tick) begin
            case (rx_bus)
              CMD_STEP: begin
                clk_pipe <= 1'b1;
                state    <= S_STEP_HI;
              end
              CMD_CONT: begin
                zero_cnt <= '0;
                state    <= S_RUN_CHK;
`ifdef DEBUG_BREAKPOINT_EN
                first_chk <= 1'b1;
`endif
              end
              CMD_RST: begin
                rst_pipe <= 1'b1;
                rst_cnt  <= RC_W'(RST_CYCLES);
                state    <= S_RESET;
              end
              CMD_DUMP: state <= S_CAPTURE;
`ifdef DEBUG_BREAKPOINT_EN
              CMD_BP: begin
                bp_cnt <= '0;
                state  <= S_BP_LOAD;
              end
              CMD_CLRBP: bp_valid <= 1'b0;
`endif
              default: ;
            endcase
          end
        end
        S_STEP_HI: begin
          clk_pipe <= 1'b0;
          state    <= S_STEP_LO;
        end
        S_STEP_LO: state <= S_CAPTURE;
        // Halt decision happens before the pulse, so a breakpoint instruction
        // is fetched but never clocked through.
        S_RUN_CHK: begin
          zero_cnt <= nz;
`ifdef DEBUG_BREAKPOINT_EN
          first_chk <= 1'b0;
`endif
          if ((nz == ZC_W'(HALT_ZERO_CNT)) || bp_hit || host_halt) begin
            state <= S_CAPTURE;
          end else begin
            clk_pipe <= 1'b1;
            state    <= S_RUN_HI;
          end
        end
        S_RUN_HI: begin
          clk_pipe <= 1'b0;
          state    <= host_halt ? S_CAPTURE : S_RUN_LO;
        end
        S_RUN_LO: state <= host_halt ? S_CAPTURE : S_RUN_CHK;
        S_RESET: begin
          rst_cnt <= rst_cnt - RC_W'(1);
          if (rst_cnt == RC_W'(1)) begin
            rst_pipe <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_BP_LOAD: begin
`ifdef DEBUG_BREAKPOINT_EN
          // Bytes arrive LSB first: shift each new byte in from the top.
          if (rx_done_tick) begin
            bp_addr <= (bp_addr >> 8) | (rx_ext << (PC_W - 8));
            if (bp_cnt == BPC_W'(BP_BYTES - 1)) begin
              bp_valid <= 1'b1;
              state    <= S_IDLE;
            end else begin
              bp_cnt <= bp_cnt + BPC_W'(1);
            end
          end
`else
          state <= S_IDLE;
`endif
        end
        S_CAPTURE: begin
          buffer    <= send_data;
          remaining <= REM_W'(DATA_BYTES);
          tx_start  <= 1'b1;
          state     <= S_SEND_START;
        end
        // tx_done_tick is ignored here, so a tick coincident with tx_start never counts.
        S_SEND_START: state <= S_SEND_WAIT;
        S_SEND_WAIT: begin
          if (tx_done_tick) begin
            if (remaining == REM_W'(1)) begin
              state <= S_IDLE;
            end else begin
              remaining <= remaining - REM_W'(1);
              buffer    <= buffer >> 8;
              tx_start  <= 1'b1;
              state     <= S_SEND_START;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          clk_pipe <= 1'b0;
          rst_pipe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_debug_ctrl.sv
// tb/tb_pipe_debug_ctrl.sv - self-checking bench for pipe_debug_ctrl
module tb_pipe_debug_ctrl;
  localparam int DB = 4;

  logic          top_clk = 1'b0;
  logic          top_rst = 1'b1;
  logic          rx_done_tick = 1'b0;
  logic [7:0]    rx_bus = 8'h00;
  logic          tx_done_tick = 1'b0;
  logic [31:0]   instruccion = 32'h0;
  logic [31:0]   pc = 32'h0;
  logic [8*DB-1:0] send_data = '0;
  logic          clk_pipe, rst_pipe, tx_start, busy;
  logic [7:0]    tx_bus;

  int total = 0;
  int bad = 0;

  // Model / observation state
  logic [7:0] exp_tx[$];
  logic [7:0] got_tx[$];
  int pulses = 0, rst_hi = 0, tx_cnt = 0;
  int instr_base = 0, instr_limit = 0, pc_base = 0;
  int resp_cnt = 0;
  bit tx_mode = 1'b0;
  logic prev_clk = 1'b0;

  pipe_debug_ctrl #(
    .DATA_BYTES(DB), .INSTR_W(32), .PC_W(32), .HALT_ZERO_CNT(5), .RST_CYCLES(3)
  ) dut (
    .top_clk(top_clk), .top_rst(top_rst), .rx_done_tick(rx_done_tick), .rx_bus(rx_bus),
    .tx_done_tick(tx_done_tick), .instruccion(instruccion), .pc(pc), .send_data(send_data),
    .clk_pipe(clk_pipe), .rst_pipe(rst_pipe), .tx_start(tx_start), .tx_bus(tx_bus), .busy(busy)
  );

  always #5 top_clk = ~top_clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected dump: DATA_BYTES bytes of the snapshot, least significant first.
  task automatic push_dump(input logic [8*DB-1:0] d);
    for (int i = 0; i < DB; i++) exp_tx.push_back(8'((d >> (8 * i)) & 'hff));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge top_clk); #1;
    rx_bus = b;
    rx_done_tick = 1'b1;
    @(posedge top_clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc, output bit last_done);
    int n = 0;
    last_done = 1'b0;
    while (busy && n < maxc) begin
      last_done = tx_done_tick;
      @(negedge top_clk);
      n++;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_tx(input int maxc, output int n);
    n = 1;
    @(negedge top_clk);
    while (!tx_start && n < maxc) begin
      @(negedge top_clk);
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_clk_pipe"}, clk_pipe, 0);
    check({name, "_rst_pipe"}, rst_pipe, 0);
    check({name, "_tx_start"}, tx_start, 0);
    check({name, "_tx_bus"}, tx_bus, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  // Per-cycle compare process: transmitted bytes against the scoreboard,
  // one-cycle clk_pipe pulses, busy whenever any output is active.
  // It also plays the pipeline: instruction and PC follow the pulse count.
  initial begin
    forever begin
      @(negedge top_clk);
      if (clk_pipe && !prev_clk) pulses++;
      check("clk_pipe_single_cycle", clk_pipe && prev_clk, 0);
      if (clk_pipe || rst_pipe || tx_start) check("busy_while_active", busy, 1);
      if (rst_pipe) rst_hi++;
      if (tx_start) begin
        tx_cnt++;
        got_tx.push_back(tx_bus);
        check("tx_expected", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0) check("tx_byte", tx_bus, exp_tx.pop_front());
      end
      prev_clk = clk_pipe;
      instruccion = ((pulses - instr_base) < instr_limit) ? 32'h13 : 32'h0;
      pc = 32'(4 * (pulses - pc_base));
    end
  end

  // UART transmitter stand-in: done 3 cycles after each tx_start, or held high.
  initial begin
    forever begin
      @(posedge top_clk); #1;
      if (tx_mode) tx_done_tick = 1'b1;
      else begin
        tx_done_tick = (resp_cnt == 1);
        if (resp_cnt > 0) resp_cnt--;
        if (tx_start) resp_cnt = 3;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int p0, t0, r0, n;
    bit ld;

    repeat (3) @(posedge top_clk);
    #1 top_rst = 1'b0;
    @(negedge top_clk);
    check_reset_outputs("reset");

    // Single step with snapshot 0x44332211
    send_data = 32'h44332211;
    push_dump(send_data);
    got_tx.delete();
    p0 = pulses; t0 = tx_cnt;
    send_byte("s");
    @(negedge top_clk); check("step_clk_c1", clk_pipe, 1);
    @(negedge top_clk); check("step_clk_c2", clk_pipe, 0);
    @(negedge top_clk); check("step_tx_c3", tx_start, 0);
    @(negedge top_clk); check("step_tx_c4", tx_start, 1);
    wait_idle("step", 100, ld);
    check("step_busy_after_4th_done", ld, 1);
    check("step_pulses", pulses - p0, 1);
    check("step_tx_count", tx_cnt - t0, 4);
    check("step_byte0", got_tx[0], 8'h11);
    check("step_byte1", got_tx[1], 8'h22);
    check("step_byte3", got_tx[3], 8'h44);
    check("step_queue_empty", exp_tx.size(), 0);

    // Continue: 10 nonzero instructions, then zeros until a 5-long streak
    instr_base = pulses; instr_limit = 10;
    send_data = 32'hA1B2C3D4;
    push_dump(send_data);
    @(negedge top_clk);
    p0 = pulses; t0 = tx_cnt;
    send_byte("c");
    wait_idle("zero_run", 400, ld);
    check("zero_run_pulses", pulses - p0, 14);
    check("zero_run_tx_count", tx_cnt - t0, 4);
    check("zero_run_queue_empty", exp_tx.size(), 0);

    // Pipeline reset pulse
    p0 = pulses; t0 = tx_cnt; r0 = rst_hi;
    send_byte("r");
    @(negedge top_clk); check("rst_c1", rst_pipe, 1);
    wait_idle("rst", 20, ld);
    check("rst_cycles", rst_hi - r0, 3);
    check("rst_no_pulses", pulses - p0, 0);
    check("rst_no_tx", tx_cnt - t0, 0);

    // Free run with nonzero instructions, stopped by host 'h'
    instr_base = pulses; instr_limit = 1000000;
    send_data = 32'h0F0E0D0C;
    push_dump(send_data);
    @(negedge top_clk);
    p0 = pulses; t0 = tx_cnt;
    send_byte("c");
    repeat (17) @(posedge top_clk);
    send_byte("h");
    r0 = pulses;
    check("halt_ran", (r0 - p0) >= 4, 1);
    wait_tx(10, n);
    check("halt_tx_latency", n, 2);
    wait_idle("halt", 100, ld);
    check("halt_no_more_pulses", pulses - r0, 0);
    check("halt_tx_count", tx_cnt - t0, 4);
    check("halt_queue_empty", exp_tx.size(), 0);

    // Dump with tx_done_tick held high: coincident ticks must not count
    send_data = 32'h55AA33CC;
    push_dump(send_data);
    tx_mode = 1'b1;
    t0 = tx_cnt; p0 = pulses;
    send_byte("d");
    @(negedge top_clk); check("dump_tx_c1", tx_start, 0);
    @(negedge top_clk); check("dump_tx_c2", tx_start, 1);
    wait_idle("dump_fast", 40, ld);
    tx_mode = 1'b0;
    check("dump_fast_tx_count", tx_cnt - t0, 4);
    check("dump_fast_no_pulses", pulses - p0, 0);
    check("dump_fast_queue_empty", exp_tx.size(), 0);
    repeat (3) @(posedge top_clk);

    // Reset during the second byte of a dump, then a clean dump
    send_data = 32'h87654321;
    push_dump(send_data);
    t0 = tx_cnt;
    send_byte("d");
    n = 0;
    while ((tx_cnt - t0) < 2 && n < 60) begin
      @(negedge top_clk);
      n++;
    end
    check("abort_reached_byte2", tx_cnt - t0, 2);
    @(posedge top_clk); #1 top_rst = 1'b1;
    @(posedge top_clk); #1 top_rst = 1'b0;
    exp_tx.delete();
    @(negedge top_clk);
    check_reset_outputs("abort");
    repeat (10) @(posedge top_clk);
    send_data = 32'h13579BDF;
    push_dump(send_data);
    got_tx.delete();
    t0 = tx_cnt;
    send_byte("d");
    wait_idle("after_abort", 100, ld);
    check("after_abort_tx_count", tx_cnt - t0, 4);
    check("after_abort_byte0", got_tx[0], 8'hDF);
    check("after_abort_byte3", got_tx[3], 8'h13);
    check("after_abort_queue_empty", exp_tx.size(), 0);

`ifdef DEBUG_BREAKPOINT_EN
    // Breakpoint at 0x10, PC advancing by 4 per pulse from 0
    send_byte("b");
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    instr_base = pulses; instr_limit = 1000000; pc_base = pulses;
    send_data = 32'hCAFEF00D;
    push_dump(send_data);
    @(negedge top_clk);
    p0 = pulses;
    send_byte("c");
    wait_idle("bp", 200, ld);
    check("bp_pulses", pulses - p0, 4);
    check("bp_pc", pc, 32'h10);
    check("bp_queue_empty", exp_tx.size(), 0);
    push_dump(send_data);
    p0 = pulses;
    send_byte("c");
    repeat (20) @(posedge top_clk);
    send_byte("h");
    check("bp_resumed", (pulses - p0) > 4, 1);
    wait_idle("bp_resume", 100, ld);
    check("bp_resume_queue_empty", exp_tx.size(), 0);
`endif

    repeat (2) @(posedge top_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
